prefetch_scheduler: RTL and testbench

Queues prefetch requests from several requesters, drops duplicates, and issues them one per cycle to the prefetch executor. The executor acknowledges a request a fixed number of cycles after it accepts it, or stays silent if it could not allocate a miss. The scheduler tracks every in-flight request against that fixed latency and re-issues silent failures, up to a bounded retry count. It sits between the prefetch sources (stride prefetcher, software prefetch) and the executor in the memory subsystem.

---
 rtl/prefetch_scheduler_pkg.sv | 36 +++
 rtl/prefetch_scheduler_if.sv | 30 +++
 rtl/prefetch_scheduler_inflight.sv | 35 +++
 rtl/prefetch_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_prefetch_scheduler.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prefetch_scheduler_pkg.sv
// Shared types for the prefetch scheduler: request/ack payloads, stat pulses, entry state.
package prefetch_scheduler_pkg;

  // Cache line is 64 bytes; the line address is addr[31:CLSIZE_E].
  localparam int unsigned CLSIZE_E = 6;
  localparam int unsigned LINE_W   = 32 - CLSIZE_E;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } prefetch_t;

  typedef struct packed {
    logic valid;
    logic existing;
  } prefetch_ack_t;

  typedef struct packed {
    logic enq;
    logic dup;
    logic hit;
    logic miss;
    logic retry;
    logic drop;
  } pf_sched_stat_t;

  typedef enum logic {
    StWait,
    StIssued
  } entry_state_e;

  function automatic logic [31:0] line_to_addr(input logic [LINE_W-1:0] line);
    return {line, {CLSIZE_E{1'b0}}};
  endfunction

endpackage

// File: rtl/prefetch_scheduler_if.sv
// Request and executor handshake bundle. The slave view belongs to the scheduler;
// the master view belongs to the surrounding requesters and executor.
interface prefetch_scheduler_if #(
  parameter int unsigned NUM_REQ = 2
) ();
  import prefetch_scheduler_pkg::*;

  prefetch_t [NUM_REQ-1:0] pf_req;
  logic      [NUM_REQ-1:0] pf_req_ready;
  prefetch_t               prefetch;
  logic                    prefetch_ready;
  prefetch_ack_t           prefetch_ack;

  modport master (
    output pf_req,
    input  pf_req_ready,
    input  prefetch,
    output prefetch_ready,
    output prefetch_ack
  );

  modport slave (
    input  pf_req,
    output pf_req_ready,
    output prefetch,
    input  prefetch_ready,
    input  prefetch_ack
  );

endinterface

// File: rtl/prefetch_scheduler_inflight.sv
// Fixed-latency tracker: slot ACK_LAT-1 holds the entry whose ack is due this cycle.
module prefetch_scheduler_inflight #(
  parameter int unsigned ACK_LAT = 3,
  parameter int unsigned IDX_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  logic [IDX_W-1:0] push_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  logic [ACK_LAT-1:0]            valid_q;
  logic [ACK_LAT-1:0][IDX_W-1:0] idx_q;

  // Shift one stage per cycle; an idle cycle pushes an empty slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      idx_q   <= '0;
    end else begin
      valid_q[0] <= push_valid;
      idx_q[0]   <= push_idx;
      for (int unsigned i = 1; i < ACK_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        idx_q[i]   <= idx_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[ACK_LAT-1];
  assign out_idx   = idx_q[ACK_LAT-1];

endmodule

// File: rtl/prefetch_scheduler.sv
// Queues prefetch requests, drops duplicate lines, issues one per cycle and
// re-issues requests the executor silently failed, up to MAX_RETRY times.
module prefetch_scheduler
  import prefetch_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned ACK_LAT     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  prefetch_scheduler_if.slave   bus,
  input  logic                  flush,
  output pf_sched_stat_t        stat
);

  localparam int unsigned IDX_W   = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int unsigned RR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [NUM_ENTRIES-1:0] valid_q, valid_d, killed_q, killed_d;
  entry_state_e           state_q [NUM_ENTRIES];
  entry_state_e           state_d [NUM_ENTRIES];
  logic [RETRY_W-1:0]     retries_q [NUM_ENTRIES];
  logic [RETRY_W-1:0]     retries_d [NUM_ENTRIES];
  logic [LINE_W-1:0]      line_q [NUM_ENTRIES];
  logic [LINE_W-1:0]      line_d [NUM_ENTRIES];
  logic [RR_W-1:0]        rr_q, rr_d;
  logic [IDX_W-1:0]       issue_ptr_q, issue_ptr_d;

  logic              win_found, free_found, dup, accept;
  logic [RR_W-1:0]   win_idx;
  logic [IDX_W-1:0]  free_idx;
  logic [LINE_W-1:0] req_line;
  logic              sel_found, issue_valid, issue_fire;
  logic [IDX_W-1:0]  sel_idx;
  logic              res_valid;
  logic [IDX_W-1:0]  res_idx;
  logic              unused_lsbs;

  // Enqueue side: round-robin winner, duplicate check, lowest free slot.
  always_comb begin
    logic [RR_W-1:0]  r;
    logic [IDX_W-1:0] e;
    r           = '0;
    e           = '0;
    win_found   = 1'b0;
    win_idx     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      r = RR_W'((32'(rr_q) + k) % NUM_REQ);
      if (!win_found && bus.pf_req[r].valid) begin
        win_found = 1'b1;
        win_idx   = r;
      end
    end
    req_line = bus.pf_req[win_idx].addr[31:CLSIZE_E];
    // Entries resolving this cycle are still valid here, so they count as duplicates.
    dup = 1'b0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (valid_q[i] && !killed_q[i] && line_q[i] == req_line) dup = 1'b1;
    end
    // Start-of-cycle occupancy: a slot freed this cycle is not reused until next cycle.
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      e = IDX_W'(i);
      if (!free_found && !valid_q[e]) begin
        free_found = 1'b1;
        free_idx   = e;
      end
    end
    accept = win_found && free_found && !flush && !rst;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      bus.pf_req_ready[i] = accept && (win_idx == RR_W'(i));
    end
  end

  // Issue side: first WAIT entry at or after issue_ptr, scanning circularly.
  always_comb begin
    logic [IDX_W-1:0] e;
    e         = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned k = 0; k < NUM_ENTRIES; k++) begin
      e = IDX_W'((32'(issue_ptr_q) + k) % NUM_ENTRIES);
      if (!sel_found && valid_q[e] && state_q[e] == StWait) begin
        sel_found = 1'b1;
        sel_idx   = e;
      end
    end
    issue_valid         = sel_found && !flush && !rst;
    issue_fire          = issue_valid && bus.prefetch_ready;
    bus.prefetch.valid  = issue_valid;
    bus.prefetch.addr   = line_to_addr(line_q[sel_idx]);
  end

  prefetch_scheduler_inflight #(
    .ACK_LAT (ACK_LAT),
    .IDX_W   (IDX_W)
  ) u_inflight (
    .clk        (clk),
    .rst        (rst),
    .push_valid (issue_fire),
    .push_idx   (sel_idx),
    .out_valid  (res_valid),
    .out_idx    (res_idx)
  );

  // Entry next-state: enqueue, issue, resolve, then flush on top; stat pulses.
  always_comb begin
    valid_d     = valid_q;
    killed_d    = killed_q;
    state_d     = state_q;
    retries_d   = retries_q;
    line_d      = line_q;
    rr_d        = rr_q;
    issue_ptr_d = issue_ptr_q;
    stat        = '0;

    if (accept) begin
      rr_d = (win_idx == RR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      if (dup) begin
        stat.dup = 1'b1;
      end else begin
        valid_d[free_idx]   = 1'b1;
        killed_d[free_idx]  = 1'b0;
        state_d[free_idx]   = StWait;
        retries_d[free_idx] = '0;
        line_d[free_idx]    = req_line;
        stat.enq            = 1'b1;
      end
    end

    if (issue_fire) begin
      state_d[sel_idx] = StIssued;
      issue_ptr_d      = (sel_idx == IDX_W'(NUM_ENTRIES - 1)) ? '0 : sel_idx + 1'b1;
    end

    if (res_valid) begin
      if (killed_q[res_idx]) begin
        valid_d[res_idx]  = 1'b0;
        killed_d[res_idx] = 1'b0;
      end else if (bus.prefetch_ack.valid) begin
        valid_d[res_idx] = 1'b0;
        if (bus.prefetch_ack.existing) stat.hit = 1'b1;
        else                           stat.miss = 1'b1;
      end else if (retries_q[res_idx] < RETRY_W'(MAX_RETRY)) begin
        state_d[res_idx]   = StWait;
        retries_d[res_idx] = retries_q[res_idx] + 1'b1;
        stat.retry         = 1'b1;
      end else begin
        valid_d[res_idx] = 1'b0;
        stat.drop        = 1'b1;
      end
    end

    // Waiting work (including a just-retried entry) is dropped now; in-flight work
    // is killed so its later ack is swallowed.
    if (flush) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        if (valid_d[i]) begin
          if (state_d[i] == StWait) valid_d[i] = 1'b0;
          else                      killed_d[i] = 1'b1;
        end
      end
    end

    if (rst) stat = '0;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      killed_q    <= '0;
      rr_q        <= '0;
      issue_ptr_q <= '0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i]   <= StWait;
        retries_q[i] <= '0;
        line_q[i]    <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      killed_q    <= killed_d;
      rr_q        <= rr_d;
      issue_ptr_q <= issue_ptr_d;
      state_q     <= state_d;
      retries_q   <= retries_d;
      line_q      <= line_d;
    end
  end

  // Offset bits of incoming requests are intentionally ignored.
  always_comb begin
    unused_lsbs = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      unused_lsbs = unused_lsbs ^ (^bus.pf_req[i].addr[CLSIZE_E-1:0]);
    end
  end

  // An ack with nothing due is an executor protocol violation.
  ack_has_slot: assert property (@(posedge clk) disable iff (rst)
    !(bus.prefetch_ack.valid && !res_valid));

endmodule

// File: tb/tb_prefetch_scheduler.sv
// Directed bench for prefetch_scheduler: reset, single miss, duplicate, retry
// exhaustion, fill, round-robin, flush and mid-operation reset.
module tb_prefetch_scheduler;
  import prefetch_scheduler_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  pf_sched_stat_t stat;
  int             checks = 0;
  int             errors = 0;

  // Stat bit order: enq dup hit miss retry drop.
  localparam logic [5:0] S_NONE  = 6'b000000;
  localparam logic [5:0] S_ENQ   = 6'b100000;
  localparam logic [5:0] S_DUP   = 6'b010000;
  localparam logic [5:0] S_HIT   = 6'b001000;
  localparam logic [5:0] S_MISS  = 6'b000100;

  prefetch_scheduler_if bus ();

  prefetch_scheduler dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .flush (flush),
    .stat  (stat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    rst                = 1'b0;
    flush              = 1'b0;
    bus.pf_req         = '0;
    bus.prefetch_ready = 1'b0;
    bus.prefetch_ack   = '0;
  endtask

  task automatic set_req(input int port, input logic [31:0] addr);
    bus.pf_req[port].valid = 1'b1;
    bus.pf_req[port].addr  = addr;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    bus.prefetch_ready = 1'b1;
    set_req(0, 32'h0000_0040);
    settle();
    checks++;
    if (bus.pf_req_ready !== 2'b00) begin
      errors++; $display("FAIL reset_cycle_ready got %b want 00", bus.pf_req_ready);
    end
    tick();
    idle();
    settle();
    checks++;
    if (bus.prefetch.valid !== 1'b0) begin
      errors++; $display("FAIL reset_pf_valid got %b want 0", bus.prefetch.valid);
    end
    checks++;
    if (bus.pf_req_ready !== 2'b00) begin
      errors++; $display("FAIL reset_ready got %b want 00", bus.pf_req_ready);
    end
    checks++;
    if (stat !== S_NONE) begin
      errors++; $display("FAIL reset_stat got %b want %b", stat, S_NONE);
    end
  endtask

  task automatic test_single();
    tick();
    set_req(0, 32'h8000_0040);
    bus.prefetch_ready = 1'b1;
    settle();
    checks++;
    if (bus.pf_req_ready !== 2'b01 || stat !== S_ENQ) begin
      errors++; $display("FAIL single_enq got rdy=%b stat=%b want rdy=01 stat=%b",
                         bus.pf_req_ready, stat, S_ENQ);
    end
    tick();
    bus.pf_req = '0;
    settle();
    checks++;
    if (bus.prefetch.valid !== 1'b1 || bus.prefetch.addr !== 32'h8000_0040) begin
      errors++; $display("FAIL single_issue got v=%b addr=%h want v=1 addr=80000040",
                         bus.prefetch.valid, bus.prefetch.addr);
    end
    tick();
    settle();
    checks++;
    if (bus.prefetch.valid !== 1'b0) begin
      errors++; $display("FAIL single_no_reissue got %b want 0", bus.prefetch.valid);
    end
    tick();
    tick();
    bus.prefetch_ack.valid    = 1'b1;
    bus.prefetch_ack.existing = 1'b0;
    settle();
    checks++;
    if (stat !== S_MISS) begin
      errors++; $display("FAIL single_miss got %b want %b", stat, S_MISS);
    end
    tick();
    bus.prefetch_ack = '0;
    settle();
    checks++;
    if (bus.prefetch.valid !== 1'b0 || stat !== S_NONE) begin
      errors++; $display("FAIL single_empty got v=%b stat=%b want v=0 stat=0",
                         bus.prefetch.valid, stat);
    end
  endtask

  task automatic test_dup();
    int issues = 0;
    tick();
    set_req(0, 32'h0000_1000);
    bus.prefetch_ready = 1'b1;
    settle();
    checks++;
    if (bus.pf_req_ready !== 2'b01 || stat !== S_ENQ) begin
      errors++; $display("FAIL dup_first got rdy=%b stat=%b want rdy=01 stat=%b",
                         bus.pf_req_ready, stat, S_ENQ);
    end
    tick();
    bus.pf_req = '0;
    set_req(1, 32'h0000_1010);
    settle();
    checks++;
    if (bus.pf_req_ready !== 2'b10 || stat !== S_DUP) begin
      errors++; $display("FAIL dup_second got rdy=%b stat=%b want rdy=10 stat=%b",
                         bus.pf_req_ready, stat, S_DUP);
    end
    if (bus.prefetch.valid && bus.prefetch_ready) issues++;
    for (int c = 2; c <= 5; c++) begin
      tick();
      bus.pf_req = '0;
      bus.prefetch_ack.valid    = (c == 4);
      bus.prefetch_ack.existing = (c == 4);
      settle();
      if (bus.prefetch.valid && bus.prefetch_ready) issues++;
      if (c == 4) begin
        checks++;
        if (stat !== S_HIT) begin
          errors++; $display("FAIL dup_hit got %b want %b", stat, S_HIT);
        end
      end
    end
    bus.prefetch_ack = '0;
    checks++;
    if (issues !== 1) begin
      errors++; $display("FAIL dup_issue_count got %0d want 1", issues);
    end
  endtask

  task automatic test_retry();
    int issues = 0;
    int retries = 0;
    int drops = 0;
    int drop_cyc = -1;
    tick();
    bus.pf_req = '0;
    set_req(1, 32'h0000_2000);
    bus.prefetch_ready = 1'b1;
    settle();
    checks++;
    if (bus.pf_req_ready !== 2'b10 || stat !== S_ENQ) begin
      errors++; $display("FAIL retry_enq got rdy=%b stat=%b want rdy=10 stat=%b",
                         bus.pf_req_ready, stat, S_ENQ);
    end
    for (int c = 1; c <= 20; c++) begin
      tick();
      bus.pf_req = '0;
      settle();
      if (bus.prefetch.valid && bus.prefetch_ready) issues++;
      if (stat.retry) retries++;
      if (stat.drop) begin
        drops++;
        drop_cyc = c;
      end
    end
    checks++;
    if (issues !== 4) begin
      errors++; $display("FAIL retry_issues got %0d want 4", issues);
    end
    checks++;
    if (retries !== 3) begin
      errors++; $display("FAIL retry_pulses got %0d want 3", retries);
    end
    checks++;
    if (drops !== 1 || drop_cyc !== 16) begin
      errors++; $display("FAIL retry_drop got n=%0d cyc=%0d want n=1 cyc=16", drops, drop_cyc);
    end
    checks++;
    if (bus.prefetch.valid !== 1'b0) begin
      errors++; $display("FAIL retry_freed got %b want 0", bus.prefetch.valid);
    end
  endtask

  task automatic test_fill();
    logic [31:0] fill_addr [4] = '{32'h3000, 32'h3040, 32'h3080, 32'h30C0};
    bus.prefetch_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.pf_req = '0;
      set_req(0, fill_addr[i]);
      settle();
      checks++;
      if (bus.pf_req_ready !== 2'b01 || stat !== S_ENQ) begin
        errors++; $display("FAIL fill_enq%0d got rdy=%b stat=%b want rdy=01 stat=%b",
                           i, bus.pf_req_ready, stat, S_ENQ);
      end
    end
    // Issue pointer sits at 1 after earlier tests, so entry 1 (0x3040) goes first.
    tick();
    set_req(0, 32'h3100);
    bus.prefetch_ready = 1'b1;
    settle();
    checks++;
    if (bus.pf_req_ready !== 2'b00) begin
      errors++; $display("FAIL fill_full got %b want 00", bus.pf_req_ready);
    end
    checks++;
    if (bus.prefetch.valid !== 1'b1 || bus.prefetch.addr !== 32'h3040) begin
      errors++; $display("FAIL fill_issue got v=%b addr=%h want v=1 addr=00003040",
                         bus.prefetch.valid, bus.prefetch.addr);
    end
    for (int c = 5; c <= 7; c++) begin
      tick();
      bus.prefetch_ready = 1'b0;
      bus.prefetch_ack.valid    = (c == 7);
      bus.prefetch_ack.existing = 1'b0;
      settle();
      checks++;
      if (bus.pf_req_ready !== 2'b00) begin
        errors++; $display("FAIL fill_hold%0d got %b want 00", c, bus.pf_req_ready);
      end
    end
    checks++;
    if (stat !== S_MISS) begin
      errors++; $display("FAIL fill_resolve got %b want %b", stat, S_MISS);
    end
    tick();
    bus.prefetch_ack = '0;
    settle();
    checks++;
    if (bus.pf_req_ready !== 2'b01 || stat !== S_ENQ) begin
      errors++; $display("FAIL fill_reuse got rdy=%b stat=%b want rdy=01 stat=%b",
                         bus.pf_req_ready, stat, S_ENQ);
    end
    tick();
    bus.pf_req = '0;
    set_req(0, 32'h3140);
    bus.prefetch_ready = 1'b1;
    flush = 1'b1;
    settle();
    checks++;
    if (bus.pf_req_ready !== 2'b00 || bus.prefetch.valid !== 1'b0 || stat !== S_NONE) begin
      errors++; $display("FAIL fill_flush got rdy=%b v=%b stat=%b want rdy=00 v=0 stat=0",
                         bus.pf_req_ready, bus.prefetch.valid, stat);
    end
    tick();
    flush = 1'b0;
    bus.pf_req = '0;
    settle();
    checks++;
    if (bus.prefetch.valid !== 1'b0) begin
      errors++; $display("FAIL fill_flushed got %b want 0", bus.prefetch.valid);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rdy;
    tick();
    idle();
    rst = 1'b1;
    settle();
    for (int i = 0; i < 5; i++) begin
      tick();
      rst = 1'b0;
      set_req(0, 32'h6000 + 32'(i) * 32'h100);
      set_req(1, 32'h7000 + 32'(i) * 32'h100);
      settle();
      exp_rdy = (i == 4) ? 2'b00 : ((i % 2 == 0) ? 2'b01 : 2'b10);
      checks++;
      if (bus.pf_req_ready !== exp_rdy) begin
        errors++; $display("FAIL rr_accept%0d got %b want %b", i, bus.pf_req_ready, exp_rdy);
      end
    end
    tick();
    idle();
    settle();
  endtask

  task automatic test_flush_reset();
    tick();
    idle();
    rst = 1'b1;
    settle();
    for (int i = 0; i < 3; i++) begin
      tick();
      rst = 1'b0;
      bus.pf_req = '0;
      set_req(0, 32'h5000 + 32'(i) * 32'h40);
      settle();
      checks++;
      if (bus.pf_req_ready !== 2'b01) begin
        errors++; $display("FAIL fl_enq%0d got %b want 01", i, bus.pf_req_ready);
      end
    end
    tick();
    bus.pf_req = '0;
    bus.prefetch_ready = 1'b1;
    settle();
    checks++;
    if (bus.prefetch.valid !== 1'b1 || bus.prefetch.addr !== 32'h5000) begin
      errors++; $display("FAIL fl_issue got v=%b addr=%h want v=1 addr=00005000",
                         bus.prefetch.valid, bus.prefetch.addr);
    end
    tick();
    bus.prefetch_ready = 1'b0;
    flush = 1'b1;
    settle();
    checks++;
    if (bus.prefetch.valid !== 1'b0 || stat !== S_NONE) begin
      errors++; $display("FAIL fl_flush got v=%b stat=%b want v=0 stat=0",
                         bus.prefetch.valid, stat);
    end
    tick();
    flush = 1'b0;
    settle();
    checks++;
    if (bus.prefetch.valid !== 1'b0) begin
      errors++; $display("FAIL fl_waits_gone got %b want 0", bus.prefetch.valid);
    end
    tick();
    bus.prefetch_ack.valid    = 1'b1;
    bus.prefetch_ack.existing = 1'b0;
    settle();
    checks++;
    if (stat !== S_NONE) begin
      errors++; $display("FAIL fl_killed_ack got %b want %b", stat, S_NONE);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.prefetch_ack = '0;
      bus.pf_req = '0;
      set_req(0, 32'h5000 + 32'(i) * 32'h40);
      settle();
      checks++;
      if (stat !== S_ENQ) begin
        errors++; $display("FAIL fl_empty%0d got %b want %b", i, stat, S_ENQ);
      end
    end
    // Issue pointer is 1 after the flushed issue of entry 0.
    tick();
    bus.pf_req = '0;
    bus.prefetch_ready = 1'b1;
    settle();
    checks++;
    if (bus.prefetch.valid !== 1'b1 || bus.prefetch.addr !== 32'h5040) begin
      errors++; $display("FAIL rs_issue got v=%b addr=%h want v=1 addr=00005040",
                         bus.prefetch.valid, bus.prefetch.addr);
    end
    tick();
    bus.prefetch_ready = 1'b0;
    rst = 1'b1;
    set_req(1, 32'h9000);
    settle();
    checks++;
    if (bus.pf_req_ready !== 2'b00 || bus.prefetch.valid !== 1'b0) begin
      errors++; $display("FAIL rs_during got rdy=%b v=%b want rdy=00 v=0",
                         bus.pf_req_ready, bus.prefetch.valid);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      idle();
      settle();
      checks++;
      if (bus.prefetch.valid !== 1'b0 || bus.pf_req_ready !== 2'b00 || stat !== S_NONE) begin
        errors++; $display("FAIL rs_after%0d got v=%b rdy=%b stat=%b want v=0 rdy=00 stat=0",
                           c, bus.prefetch.valid, bus.pf_req_ready, stat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_dup();
    test_retry();
    test_fill();
    test_round_robin();
    test_flush_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
